layered_objects_mux: RTL and testbench
======================================

// Module: layered_objects_mux
// PURPOSE
//  Parametrised N-layer pixel priority mux between the object drawers and the VGA output stage.
//  Selects the highest-priority enabled, non-transparent layer per pixel, else the background MIF.
//  Adds a game-over sequencer (flash, then hold, then restart) and a 2-cycle registered pipeline.
// PARAMETERS
//  NUM_LAYERS   8      object layers; layer 0 = highest priority
//  RGB_W        8      pixel width (RRRGGGBB at 8)
//  TRANSPARENT  8'hFF  colour key; a requesting layer with this RGB is skipped
//  FLASH_FRAMES 4      frames spent in FLASH before OVER (>=1)
//  (local) IDX_W = $clog2(NUM_LAYERS+1)
// PORTS
//  clk                  in   1                 pixel clock
//  reset                in   1                 async, active-high
//  startOfFrame         in   1                 1-cycle pulse per frame
//  layerDrawingRequest  in   NUM_LAYERS        bit i = layer i wants this pixel
//  layerRGB             in   NUM_LAYERS*RGB_W  layer i at [i*RGB_W +: RGB_W]
//  layerEnable          in   NUM_LAYERS        per-layer mask, 0 = layer ignored
//  RGB_MIF              in   RGB_W             background pixel
//  RGB_ENDGAME_MIF      in   RGB_W             game-over screen pixel
//  gameOver             in   1                 game-over request (level or pulse)
//  restart              in   1                 return-to-play request
//  RGBOut               out  RGB_W             final pixel
//  topLayer             out  IDX_W             winning layer index; NUM_LAYERS = background
//  muxState             out  2                 0 PLAY, 1 FLASH, 2 OVER
// BEHAVIOUR
//  - Reset: RGBOut=0, topLayer=NUM_LAYERS, muxState=PLAY, frame counter=0, pipeline cleared.
//  - Stage 1 (reg): hit[i] = req[i] & en[i] & (rgb[i]!=TRANSPARENT); win = lowest i with hit;
//    none -> win=NUM_LAYERS, pix=RGB_MIF. Register win, pix, RGB_ENDGAME_MIF.
//  - Stage 2 (reg): RGBOut chosen by state, as below. Latency = 2 clks, fully pipelined.
//  - topLayer follows stage-1 result with 2-clk latency in every state.
//  - FSM, evaluated every clk:
//    PLAY : RGBOut = stage-1 pix. gameOver=1 -> FLASH, frameCnt=0.
//    FLASH: on each startOfFrame, frameCnt++. RGBOut = endgame pix if frameCnt[0], else scene pix.
//           startOfFrame with frameCnt==FLASH_FRAMES-1 -> OVER.
//    OVER : RGBOut = endgame pix; gameOver ignored (sticky).
//  - restart=1 in any state -> PLAY next clk, frameCnt=0. Restart beats gameOver if both are high.
//  - gameOver held high after restart -> PLAY for 1 clk, then FLASH again.
//  - State change takes effect on the stage-2 pixel of the next clk; pipelined pixels are not flushed.
//  - layerEnable=0 or transparent RGB lets lower layers show through. All hits masked -> background.
//  - Async reset mid-frame -> immediate reset values; no frame-alignment recovery needed.
// CONFIGURATION
//  `define OBJECTS_MUX_COLLISION_EN adds output collisionFlags [NUM_LAYERS]:
//    sticky per frame; bit i set when hit[i] and any other hit[j] occur on the same pixel.
//    Flags are presented and cleared on startOfFrame (value = last frame's OR). Reset = 0.
//  Without the macro: port absent, no collision logic.
// TESTING
//  1 reset high, then low; all req=0, RGB_MIF=8'h12 -> RGBOut=8'h12 after 2 clks, topLayer=NUM_LAYERS.
//  2 req[2]=req[5]=1, rgb2=8'hE0, rgb5=8'h1C -> RGBOut=8'hE0, topLayer=2; en[2]=0 -> 8'h1C, topLayer=5.
//  3 req[0]=1, rgb0=8'hFF (transparent), req[3]=1, rgb3=8'h03 -> RGBOut=8'h03, topLayer=3.
//  4 gameOver pulse, FLASH_FRAMES=4, 4 startOfFrame pulses -> output alternates scene/endgame,
//    then OVER; later gameOver pulses -> no change.
//  5 in OVER: restart and gameOver asserted on the same clk -> muxState=PLAY, scene pixels resume.
//  6 (COLLISION_EN) req[1]&req[4] on one pixel, then startOfFrame -> collisionFlags=5'b10010
//    (bits 1 and 4); next clean frame -> flags=0.

Source files
------------

// File: rtl/layered_objects_mux.sv
// rtl/layered_objects_mux.sv - N-layer pixel priority mux with game-over sequencer and 2-clk pipeline.
// Optional per-frame collision flags are built when OBJECTS_MUX_COLLISION_EN is defined.
module layered_objects_mux #(
  parameter int NUM_LAYERS = 8,
  parameter int RGB_W = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT = 8'hFF,
  parameter int FLASH_FRAMES = 4,
  localparam int IDX_W = $clog2(NUM_LAYERS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       layerDrawingRequest,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  input  logic [RGB_W-1:0]            RGB_MIF,
  input  logic [RGB_W-1:0]            RGB_ENDGAME_MIF,
  input  logic                        gameOver,
  input  logic                        restart,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [IDX_W-1:0]            topLayer,
`ifdef OBJECTS_MUX_COLLISION_EN
  output logic [1:0]                  muxState,
  output logic [NUM_LAYERS-1:0]       collisionFlags
`else
  output logic [1:0]                  muxState
`endif
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_FLASH = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  logic [NUM_LAYERS-1:0] hit;
  logic [IDX_W-1:0]      win_d, win_q;
  logic [RGB_W-1:0]      pix_d, pix_q;
  logic [RGB_W-1:0]      endpix_d, endpix_q;
  state_t                state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic [RGB_W-1:0]      rgb_d, rgb_q;
  logic [IDX_W-1:0]      top_d, top_q;

  // Descending scan so the last assignment made is the lowest-index (highest-priority) hit.
  always_comb begin
    hit   = '0;
    win_d = IDX_W'(NUM_LAYERS);
    pix_d = RGB_MIF;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      hit[i] = layerDrawingRequest[i] & layerEnable[i] &
               (layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT);
      if (hit[i]) begin
        win_d = IDX_W'(i);
        pix_d = layerRGB[i*RGB_W +: RGB_W];
      end
    end
  end

  assign endpix_d = RGB_ENDGAME_MIF;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = ST_PLAY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (gameOver) begin
            state_d = ST_FLASH;
            cnt_d   = '0;
          end
        end
        ST_FLASH: begin
          if (startOfFrame) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FLASH_FRAMES - 1)) state_d = ST_OVER;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Stage 2 uses the current registered state, so a state change shows up one clk later.
  always_comb begin
    top_d = win_q;
    case (state_q)
      ST_PLAY:  rgb_d = pix_q;
      ST_FLASH: rgb_d = cnt_q[0] ? endpix_q : pix_q;
      default:  rgb_d = endpix_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q    <= IDX_W'(NUM_LAYERS);
      pix_q    <= '0;
      endpix_q <= '0;
      state_q  <= ST_PLAY;
      cnt_q    <= '0;
      rgb_q    <= '0;
      top_q    <= IDX_W'(NUM_LAYERS);
    end else begin
      win_q    <= win_d;
      pix_q    <= pix_d;
      endpix_q <= endpix_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rgb_q    <= rgb_d;
      top_q    <= top_d;
    end
  end

  assign RGBOut   = rgb_q;
  assign topLayer = top_q;
  assign muxState = state_q;

`ifdef OBJECTS_MUX_COLLISION_EN
  logic [NUM_LAYERS-1:0] coll_now;
  logic [NUM_LAYERS-1:0] acc_d, acc_q;
  logic [NUM_LAYERS-1:0] flags_d, flags_q;

  // Two or more hits on one pixel: every hitting layer is part of the collision.
  assign coll_now = (|(hit & (hit - NUM_LAYERS'(1)))) ? hit : '0;

  always_comb begin
    acc_d   = acc_q | coll_now;
    flags_d = flags_q;
    if (startOfFrame) begin
      flags_d = acc_q;
      acc_d   = coll_now;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  assign collisionFlags = flags_q;
`endif

endmodule

// File: tb/tb_layered_objects_mux.sv
// tb/tb_layered_objects_mux.sv - directed plus randomized bench for layered_objects_mux.
module tb_layered_objects_mux;
  localparam int NL = 8;
  localparam int RW = 8;
  localparam int FF = 4;
  localparam int IW = $clog2(NL + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, sof, go, rs;
  logic [NL-1:0]     req, en;
  logic [NL*RW-1:0]  rgb;
  logic [RW-1:0]     mif, emif;
  logic [RW-1:0]     rgb_out;
  logic [IW-1:0]     top;
  logic [1:0]        st;
`ifdef OBJECTS_MUX_COLLISION_EN
  logic [NL-1:0]     cflags;
`endif

  layered_objects_mux dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(sof),
    .layerDrawingRequest(req),
    .layerRGB(rgb),
    .layerEnable(en),
    .RGB_MIF(mif),
    .RGB_ENDGAME_MIF(emif),
    .gameOver(go),
    .restart(rs),
    .RGBOut(rgb_out),
    .topLayer(top),
`ifdef OBJECTS_MUX_COLLISION_EN
    .muxState(st),
    .collisionFlags(cflags)
`else
    .muxState(st)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: game state, flash frame count, one pending pixel, collision accumulators.
  int            m_st, m_cnt;
  logic [RW-1:0] pend_rgb, cur_rgb;
  int            pend_top, cur_top;
  logic [NL-1:0] m_acc, m_flags;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void scene(output logic [RW-1:0] p, output int w);
    logic [RW-1:0] c;
    p = mif;
    w = NL;
    for (int i = 0; i < NL; i++) begin
      c = rgb[i*RW +: RW];
      if (req[i] && en[i] && c != 8'hFF) begin
        p = c;
        w = i;
        return;
      end
    end
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0;
    pend_rgb = '0; pend_top = NL;
    cur_rgb = '0; cur_top = NL;
    m_acc = '0; m_flags = '0;
  endtask

  task automatic model_edge();
    logic [RW-1:0] sp;
    int w;
    logic [NL-1:0] h, coll;
    scene(sp, w);
    if (rs) begin
      m_st = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      if (go) begin m_st = 1; m_cnt = 0; end
    end else if (m_st == 1) begin
      if (sof) begin
        if (m_cnt == FF - 1) m_st = 2;
        m_cnt++;
      end
    end
    cur_rgb = pend_rgb;
    cur_top = pend_top;
    if (m_st == 0) pend_rgb = sp;
    else if (m_st == 1) pend_rgb = (m_cnt % 2 == 1) ? emif : sp;
    else pend_rgb = emif;
    pend_top = w;
    for (int i = 0; i < NL; i++) h[i] = req[i] & en[i] & (rgb[i*RW +: RW] != 8'hFF);
    coll = ($countones(h) >= 2) ? h : '0;
    if (sof) begin
      m_flags = m_acc;
      m_acc = coll;
    end else begin
      m_acc = m_acc | coll;
    end
  endtask

  task automatic check_all();
    chk("rgb_out", 32'(rgb_out), 32'(cur_rgb));
    chk("top_layer", 32'(top), 32'(cur_top));
    chk("mux_state", 32'(st), 32'(m_st));
`ifdef OBJECTS_MUX_COLLISION_EN
    chk("collision_flags", 32'(cflags), 32'(m_flags));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  task automatic set_layer(input int i, input logic [RW-1:0] v);
    rgb[i*RW +: RW] = v;
  endtask

  initial begin
    reset = 1'b1; sof = 1'b0; go = 1'b0; rs = 1'b0;
    req = '0; en = '1; rgb = '0; mif = 8'h12; emif = 8'hAA;
    model_reset();
    #2;
    do_reset();

    // Background only
    steps(2);
    chk("bg_rgb", 32'(rgb_out), 32'h12);
    chk("bg_top", 32'(top), 32'(NL));

    // Priority and enable masking
    set_layer(2, 8'hE0); set_layer(5, 8'h1C);
    req = 8'b0010_0100;
    steps(2);
    chk("prio_rgb", 32'(rgb_out), 32'hE0);
    chk("prio_top", 32'(top), 32'd2);
    en[2] = 1'b0;
    steps(2);
    chk("mask_rgb", 32'(rgb_out), 32'h1C);
    chk("mask_top", 32'(top), 32'd5);
    en = '1;

    // Transparent colour key
    set_layer(0, 8'hFF); set_layer(3, 8'h03);
    req = 8'b0000_1001;
    steps(2);
    chk("transp_rgb", 32'(rgb_out), 32'h03);
    chk("transp_top", 32'(top), 32'd3);

    // Game-over flash sequence
    req = '0;
    go = 1'b1; step(); go = 1'b0;
    chk("flash_enter", 32'(st), 32'd1);
    steps(2);
    chk("flash_f0", 32'(rgb_out), 32'h12);
    for (int f = 1; f <= FF; f++) begin
      sof = 1'b1; step(); sof = 1'b0;
      steps(2);
      chk("flash_frame", 32'(rgb_out), (f % 2 == 1 || f == FF) ? 32'hAA : 32'h12);
    end
    chk("over_state", 32'(st), 32'd2);
    go = 1'b1; step(); go = 1'b0;
    steps(3);
    chk("over_sticky", 32'(st), 32'd2);
    chk("over_rgb", 32'(rgb_out), 32'hAA);

    // Restart beats gameOver
    rs = 1'b1; go = 1'b1; step();
    rs = 1'b0; go = 1'b0;
    chk("restart_state", 32'(st), 32'd0);
    steps(2);
    chk("restart_rgb", 32'(rgb_out), 32'h12);

    // gameOver held through restart: PLAY one clk, then FLASH
    go = 1'b1; step();
    rs = 1'b1; step(); rs = 1'b0;
    chk("hold_play", 32'(st), 32'd0);
    step();
    chk("hold_flash", 32'(st), 32'd1);
    go = 1'b0;
    rs = 1'b1; step(); rs = 1'b0;

`ifdef OBJECTS_MUX_COLLISION_EN
    set_layer(1, 8'h40); set_layer(4, 8'h08);
    req = 8'b0001_0010;
    step();
    req = '0;
    sof = 1'b1; step(); sof = 1'b0;
    chk("coll_flags", 32'(cflags), 32'h12);
    steps(2);
    sof = 1'b1; step(); sof = 1'b0;
    chk("coll_clear", 32'(cflags), 32'h0);
`endif

    // Randomized traffic, with an asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      req  = NL'($urandom);
      en   = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '1;
      for (int i = 0; i < NL; i++)
        set_layer(i, ($urandom_range(0, 3) == 0) ? 8'hFF : RW'($urandom));
      mif  = RW'($urandom);
      emif = RW'($urandom);
      sof  = (n % 16 == 0);
      go   = ($urandom_range(0, 29) == 0);
      rs   = ($urandom_range(0, 59) == 0);
      if (n == 200) begin
        #3;
        do_reset();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
